ls_mem_ctrl: RTL and testbench

Data-side memory responder for the load/store buffer. It accepts one load or store request at a time on the LSB request interface (address, store value, read/write, access type, activate). It performs the access as a little-endian byte-serial sequence on the 8-bit RAM port. It then returns a single-cycle done pulse, carrying the sign- or zero-extended load value, that the LSB uses to pop its head entry and submit to the ROB.

---
 rtl/ls_mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ls_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_mem_ctrl.sv
// Data-side memory responder: serialises one LSB load/store into little-endian
// byte accesses on the 8-bit RAM port and returns a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for activate_in
// READ  | issuing byte addresses and capturing returned bytes
// WRITE | writing one byte per cycle (I/O stores stall on a full buffer)
// DONE  | completion pulse carrying the extended load value
module ls_mem_ctrl #(
   parameter logic [31:0] IO_BASE = 32'h0003_0000,
   parameter int          RD_LAT  = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        activate_in,
   input  logic        r_nw_in,
   input  logic [2:0]  type_in,
   input  logic [31:0] ls_addr_in,
   input  logic [31:0] st_val_in,
   output logic [31:0] ld_val_out,
   output logic        ls_done_out,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   if (RD_LAT != 1) begin : g_rd_lat_check
      $error("ls_mem_ctrl supports RD_LAT == 1 only");
   end

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q, st_val_q, data_q;
   logic [2:0]  type_q;
   logic        r_nw_q;
   logic [2:0]  len_q, issue_q, cap_q;
   logic        pend_q, rewind_q;

   logic        is_io, wr_go, last_cap;
   logic [2:0]  rd_idx;
   logic [31:0] st_shift, ext_val;

   assign is_io    = (addr_q[17:16] == IO_BASE[17:16]);
   assign rd_idx   = rewind_q ? cap_q : issue_q;
   assign st_shift = st_val_q >> {issue_q[1:0], 3'b000};
   assign wr_go    = (state == S_WRITE) && rdy_in && !(is_io && io_buffer_full);
   assign last_cap = pend_q && !rewind_q && (cap_q == len_q - 3'd1);

   always_comb begin
      ext_val = 32'd0;
      case (type_q[1:0])
         2'b00:   ext_val = data_q;
         2'b01:   ext_val = {{16{type_q[2] & data_q[15]}}, data_q[15:0]};
         2'b10:   ext_val = {{24{type_q[2] & data_q[7]}}, data_q[7:0]};
         default: ext_val = 32'd0;
      endcase
   end

   always_comb begin
      state_nx    = state;
      mem_wr      = 1'b0;
      mem_a       = 32'd0;
      mem_dout    = 8'd0;
      ls_done_out = 1'b0;
      ld_val_out  = 32'd0;
      case (state)
         S_IDLE: begin
            if (activate_in) begin
               if (type_in[1:0] == 2'b11) state_nx = S_DONE;
               else if (r_nw_in)          state_nx = S_READ;
               else                       state_nx = S_WRITE;
            end
         end
         S_READ: begin
            if (rd_idx < len_q) mem_a = addr_q + {29'd0, rd_idx};
            if (last_cap) state_nx = S_DONE;
         end
         S_WRITE: begin
            mem_a    = addr_q + {29'd0, issue_q};
            mem_dout = st_shift[7:0];
            mem_wr   = wr_go;
            if (wr_go && (issue_q == len_q - 3'd1)) state_nx = S_DONE;
         end
         S_DONE: begin
            ls_done_out = 1'b1;
            ld_val_out  = r_nw_q ? ext_val : 32'd0;
            state_nx    = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (!rdy_in) state_nx = state;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) state <= S_IDLE;
      else        state <= state_nx;
   end

   // A pause inside READ loses the byte in flight; rewind_q re-presents the
   // oldest uncaptured address on the first ready cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_q   <= 32'd0;
         st_val_q <= 32'd0;
         data_q   <= 32'd0;
         type_q   <= 3'd0;
         r_nw_q   <= 1'b0;
         len_q    <= 3'd0;
         issue_q  <= 3'd0;
         cap_q    <= 3'd0;
         pend_q   <= 1'b0;
         rewind_q <= 1'b0;
      end else if (!rdy_in) begin
         if (state == S_READ) rewind_q <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (activate_in) begin
                  addr_q   <= ls_addr_in;
                  st_val_q <= st_val_in;
                  type_q   <= type_in;
                  r_nw_q   <= r_nw_in;
                  data_q   <= 32'd0;
                  issue_q  <= 3'd0;
                  cap_q    <= 3'd0;
                  pend_q   <= 1'b0;
                  rewind_q <= 1'b0;
                  case (type_in[1:0])
                     2'b00:   len_q <= 3'd4;
                     2'b01:   len_q <= 3'd2;
                     2'b10:   len_q <= 3'd1;
                     default: len_q <= 3'd0;
                  endcase
               end
            end
            S_READ: begin
               if (rewind_q) begin
                  issue_q  <= cap_q + 3'd1;
                  pend_q   <= 1'b1;
                  rewind_q <= 1'b0;
               end else begin
                  if (pend_q) begin
                     case (cap_q[1:0])
                        2'd0: data_q[7:0]   <= mem_din;
                        2'd1: data_q[15:8]  <= mem_din;
                        2'd2: data_q[23:16] <= mem_din;
                        2'd3: data_q[31:24] <= mem_din;
                        default: ;
                     endcase
                     cap_q <= cap_q + 3'd1;
                  end
                  if (issue_q < len_q) begin
                     issue_q <= issue_q + 3'd1;
                     pend_q  <= 1'b1;
                  end else begin
                     pend_q  <= 1'b0;
                  end
               end
            end
            S_WRITE: if (wr_go) issue_q <= issue_q + 3'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ls_mem_ctrl.sv
// Scoreboard bench for ls_mem_ctrl: a byte-array reference model predicts each
// done pulse; a negedge monitor pops and compares whenever ls_done_out rises.
module tb_ls_mem_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        activate_in = 1'b0;
   logic        r_nw_in = 1'b0;
   logic [2:0]  type_in = 3'd0;
   logic [31:0] ls_addr_in = 32'd0;
   logic [31:0] st_val_in = 32'd0;
   logic [31:0] ld_val_out;
   logic        ls_done_out;
   logic [7:0]  mem_din = 8'd0;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full = 1'b0;

   always #5 clk_in = ~clk_in;

   ls_mem_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .activate_in(activate_in),
      .r_nw_in(r_nw_in), .type_in(type_in), .ls_addr_in(ls_addr_in), .st_val_in(st_val_in),
      .ld_val_out(ld_val_out), .ls_done_out(ls_done_out), .mem_din(mem_din),
      .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
   );

   typedef struct { logic [31:0] val; int cyc; bit chk; } exp_t;
   exp_t        exp_q[$];
   logic [7:0]  ram [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];
   int          total = 0, bad = 0, cyc = 0, done_count = 0, io_wr_cnt = 0;
   bit          rand_rdy = 1'b0, done_prev = 1'b0;

   // RAM environment: one-cycle read latency, byte writes.
   always @(posedge clk_in) begin
      cyc++;
      if (mem_wr) begin
         ram[mem_a] = mem_dout;
         if (mem_a == 32'h0003_0000) io_wr_cnt++;
      end
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
   end

   always @(posedge clk_in) begin
      #2;
      if (rand_rdy) rdy_in = ($urandom_range(0, 3) != 0);
   end

   task automatic check(string nm, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   always @(negedge clk_in) begin
      exp_t e;
      if (rst_in) begin
         done_prev = 1'b0;
      end else begin
         if (ls_done_out && !done_prev) begin
            done_count++;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ld_val", ld_val_out, e.val);
               if (e.chk) check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
         if (!ls_done_out) check("ld_val_idle", ld_val_out, 32'd0);
         done_prev = ls_done_out;
      end
   end

   task automatic step();
      @(posedge clk_in);
      #2;
   endtask

   function automatic logic [7:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ram_rd(logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   function automatic int nbytes(logic [2:0] t);
      case (t[1:0])
         2'b00:   return 4;
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(logic [2:0] t, logic [31:0] a);
      int          n;
      logic [31:0] v;
      n = nbytes(t);
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v + (32'(ref_rd(a + 32'(i))) << (8 * i));
      if (t[2] && n > 0 && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
      return v;
   endfunction

   task automatic poke(logic [31:0] a, logic [7:0] d);
      ram[a] = d;
      ref_mem[a] = d;
   endtask

   task automatic issue(bit rnw, logic [2:0] t, logic [31:0] a, logic [31:0] sv,
                        int extra, int acc_ofs, bit chk);
      int          n, lat;
      logic [31:0] e, tmp;
      n = nbytes(t);
      if (n == 0) lat = 1;
      else        lat = rnw ? n + 2 : n + 1;
      e = rnw ? model_load(t, a) : 32'd0;
      if (!rnw)
         for (int i = 0; i < n; i++) begin
            tmp = sv >> (8 * i);
            ref_mem[a + 32'(i)] = tmp[7:0];
         end
      exp_q.push_back('{e, cyc + acc_ofs + lat - 1 + extra, chk});
      r_nw_in = rnw; type_in = t; ls_addr_in = a; st_val_in = sv;
      activate_in = 1'b1;
   endtask

   task automatic wait_done(bit drop);
      int b;
      b = 0;
      step();
      while (!ls_done_out && b < 200) begin
         step();
         b++;
      end
      if (b >= 200) check("done_timeout", 32'd0, 32'd1);
      if (drop) begin
         activate_in = 1'b0;
         step();
      end
   endtask

   task automatic check_mem(logic [31:0] a);
      for (int i = 0; i < 4; i++) check("mem_byte", 32'(ram_rd(a + 32'(i))), 32'(ref_rd(a + 32'(i))));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
      poke(32'h200, 8'h80); poke(32'h201, 8'hFF); poke(32'h302, 8'h11);
      for (int i = 0; i < 32'h104; i++) poke(32'h1000 + 32'(i), 8'($urandom));

      repeat (3) step();
      check("rst_done", 32'(ls_done_out), 32'd0);
      check("rst_wr", 32'(mem_wr), 32'd0);
      check("rst_a", mem_a, 32'd0);
      check("rst_dout", 32'(mem_dout), 32'd0);
      check("rst_ldval", ld_val_out, 32'd0);
      rst_in = 1'b0;
      step();

      // word load with address sequence
      issue(1'b1, 3'b000, 32'h100, 32'd0, 0, 1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("lw_addr", mem_a, 32'h100 + 32'(i));
         check("lw_wr", 32'(mem_wr), 32'd0);
      end
      wait_done(1'b1);

      // byte/half loads, signed and unsigned, plus invalid type
      issue(1'b1, 3'b110, 32'h200, 32'd0, 0, 1, 1'b1); wait_done(1'b1);
      issue(1'b1, 3'b010, 32'h200, 32'd0, 0, 1, 1'b1); wait_done(1'b1);
      issue(1'b1, 3'b101, 32'h200, 32'd0, 0, 1, 1'b1); wait_done(1'b1);
      issue(1'b1, 3'b001, 32'h200, 32'd0, 0, 1, 1'b1); wait_done(1'b1);
      issue(1'b1, 3'b011, 32'h100, 32'd0, 0, 1, 1'b1); wait_done(1'b1);

      // half store
      issue(1'b0, 3'b001, 32'h300, 32'hAABBCCDD, 0, 1, 1'b1);
      wait_done(1'b1);
      check("sh_b0", 32'(ram_rd(32'h300)), 32'hDD);
      check("sh_b1", 32'(ram_rd(32'h301)), 32'hCC);
      check("sh_b2", 32'(ram_rd(32'h302)), 32'h11);

      // I/O store stalled three cycles by a full buffer
      io_buffer_full = 1'b1;
      issue(1'b0, 3'b010, 32'h0003_0000, 32'h0000_005A, 3, 1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("io_stall_wr", 32'(mem_wr), 32'd0);
      end
      step();
      io_buffer_full = 1'b0;
      #1;
      check("io_resume_wr", 32'(mem_wr), 32'd1);
      wait_done(1'b1);
      check("io_wr_cnt", 32'(io_wr_cnt), 32'd1);
      check("io_byte", 32'(ram_rd(32'h0003_0000)), 32'h5A);

      // back-to-back with activate held through DONE
      dc = done_count;
      issue(1'b1, 3'b010, 32'h200, 32'd0, 0, 1, 1'b1);
      wait_done(1'b0);
      issue(1'b1, 3'b000, 32'h100, 32'd0, 0, 2, 1'b1);
      wait_done(1'b1);
      repeat (3) step();
      check("b2b_pulses", 32'(done_count - dc), 32'd2);

      // pause mid word-load
      issue(1'b1, 3'b000, 32'h100, 32'd0, 0, 1, 1'b0);
      step(); step();
      rdy_in = 1'b0;
      step(); step();
      rdy_in = 1'b1;
      wait_done(1'b1);

      // reset in the middle of a store
      issue(1'b0, 3'b000, 32'h2000, 32'hCAFEBABE, 0, 1, 1'b0);
      step(); step();
      rst_in = 1'b1;
      activate_in = 1'b0;
      step(); step();
      exp_q.delete();
      rst_in = 1'b0;
      dc = done_count;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_wr", 32'(mem_wr), 32'd0);
         check("post_rst_a", mem_a, 32'd0);
      end
      check("post_rst_pulses", 32'(done_count - dc), 32'd0);
      issue(1'b1, 3'b000, 32'h100, 32'd0, 0, 1, 1'b1);
      wait_done(1'b1);

      // randomized traffic; second half with random rdy pauses
      for (int it = 0; it < 40; it++) begin
         bit          rnw;
         logic [2:0]  t;
         logic [31:0] a, sv;
         rand_rdy = (it >= 20);
         rnw = 1'($urandom_range(0, 1));
         t   = 3'($urandom_range(0, 7));
         a   = 32'h1000 + 32'($urandom_range(0, 250));
         sv  = $urandom;
         issue(rnw, t, a, sv, 0, 1, !rand_rdy);
         wait_done(1'b1);
         if (!rnw) check_mem(a);
      end
      rand_rdy = 1'b0;
      step();
      rdy_in = 1'b1;
      repeat (4) step();
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
